buzzer_arbiter: RTL and testbench
=================================

BUZZER_ARBITER -- requirements
Module: buzzer_arbiter

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 4, meaning the number of forced-silence cycles inserted between any two distinct sounded notes.
REQ-002 The block SHALL have parameter MIN_HOLD, default 8, meaning the minimum number of cycles a granted note sounds before release.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 3 bits: per-source request; bit 0 is free-play keys, bit 1 is auto player, bit 2 is learn prompt.
REQ-006 The block SHALL have ports note0, note1 and note2, input, 5 bits each: per-source note code; 0 means rest.
REQ-007 The block SHALL have port en_mask, input, 3 bits: per-source enable, driven by the mode decoder.
REQ-008 The block SHALL have port note, output, 5 bits, registered: the note code driven to the buzzer.
REQ-009 The block SHALL have port grant, output, 3 bits, one-hot or zero, registered: the source currently owning the buzzer.
REQ-010 The block SHALL have port busy, output, 1 bit, registered: high in PLAY or GAP.

Function
REQ-011 Source i SHALL be valid when req[i], en_mask[i] and note_i != 0 are all true.
REQ-012 Priority SHALL be fixed: source 0 over source 1 over source 2.
REQ-013 The FSM SHALL have exactly three states: IDLE, PLAY and GAP.
REQ-014 In IDLE, the block SHALL hold note=0, grant=0 and busy=0.
REQ-015 In IDLE, if any source is valid at edge N, the block SHALL enter PLAY with the highest-priority valid source granted, and note/grant SHALL show it after edge N (one-cycle latency).
REQ-016 On entering PLAY, the hold counter SHALL clear and then increment each PLAY cycle, saturating at MIN_HOLD.
REQ-017 In PLAY, note SHALL be latched; it SHALL NOT follow note_i combinationally.
REQ-018 In PLAY, if the granted source changes to a different nonzero code, the block SHALL enter GAP and then re-enter PLAY with the new code, re-arbitrated.
REQ-019 In PLAY, if the granted source becomes invalid while hold < MIN_HOLD, note SHALL stay latched until hold reaches MIN_HOLD, then the block SHALL enter GAP.
REQ-020 In PLAY, if en_mask clears the granted bit, the block SHALL enter GAP on the next edge regardless of hold.
REQ-021 In PLAY, a valid source of higher priority than the granted source SHALL preempt immediately (no MIN_HOLD wait) via GAP.
REQ-022 If preemption and release occur on the same edge, preemption SHALL govern the transition.
REQ-023 An equal or lower-priority request SHALL never preempt.
REQ-024 In GAP, the block SHALL drive note=0, grant=0 and busy=1 for exactly GAP_CYCLES cycles.
REQ-025 At the end of GAP, the block SHALL re-arbitrate on the last GAP edge and enter PLAY if any source is valid, else IDLE.
REQ-026 If GAP_CYCLES=0, GAP SHALL last one cycle.
REQ-027 Counters SHALL be sized by $clog2(max(param)+1) and SHALL never wrap.

Reset
REQ-028 Asserting rst SHALL immediately force IDLE, note=0, grant=0, busy=0 and clear both counters, including mid-PLAY and mid-GAP.
REQ-029 After rst deasserts, the first arbitration SHALL occur on the first rising clk edge.

Structure
REQ-030 A shared package SHALL hold the NOTE_W=5 and NOTE_REST=0 constants, the source indices SRC_KEYS/SRC_AUTO/SRC_LEARN, and the FSM state typedef.
REQ-031 The block SHALL have no sub-module; FSM, priority pick and both counters SHALL be inline.

Verification
REQ-032 Idle to play: req=010, note1=8, mask=111 -> next cycle note=8, grant=010, busy=1.
REQ-033 Preempt: source 1 playing note 8; req0 with note0=12 -> 4 cycles note=0/grant=0, then note=12, grant=001.
REQ-034 Min hold: source 2 note 5 granted, req2 drops after 2 cycles -> note=5 held until 8 PLAY cycles total, then 4-cycle gap, then IDLE.
REQ-035 Note change: auto note 10->9 while granted -> exactly 4 rest cycles, then note=9.
REQ-036 Mask kill: mask 111->101 while source 1 plays -> next edge GAP, no MIN_HOLD wait.
REQ-037 Reset: rst pulsed mid-GAP and mid-PLAY -> outputs zero asynchronously; after release, restart from IDLE.

Source files
------------

// File: rtl/buzzer_arbiter_pkg.sv
// Shared constants, source indices and FSM state type for the buzzer arbiter.
package buzzer_arbiter_pkg;

   localparam int NOTE_W = 5;
   localparam logic [NOTE_W-1:0] NOTE_REST = '0;

   localparam int N_SRC     = 3;
   localparam int SRC_KEYS  = 0;
   localparam int SRC_AUTO  = 1;
   localparam int SRC_LEARN = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Isolates the lowest set bit, which is the highest-priority source.
   function automatic logic [N_SRC-1:0] pick_first(input logic [N_SRC-1:0] v);
      return v & (~v + 3'd1);
   endfunction

endpackage

// File: rtl/buzzer_arbiter.sv
// Fixed-priority buzzer arbiter: grants one note source at a time, enforces a
// minimum sounding time and a silent gap between distinct notes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | buzzer silent, nothing granted, waiting for a valid source
// PLAY    | granted source's latched note is sounding
// GAP     | forced silence before re-arbitration
module buzzer_arbiter
   import buzzer_arbiter_pkg::*;
#(
   parameter int GAP_CYCLES = 4,
   parameter int MIN_HOLD   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_SRC-1:0]  req,
   input  logic [NOTE_W-1:0] note0,
   input  logic [NOTE_W-1:0] note1,
   input  logic [NOTE_W-1:0] note2,
   input  logic [N_SRC-1:0]  en_mask,
   output logic [NOTE_W-1:0] note,
   output logic [N_SRC-1:0]  grant,
   output logic              busy
);

   localparam int CNT_MAX = (GAP_CYCLES > MIN_HOLD) ? GAP_CYCLES : MIN_HOLD;
   localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MIN_HOLD);
   localparam logic [CNT_W:0]   HOLD_CMP = (CNT_W + 1)'(MIN_HOLD);
   // A zero-length gap still costs one silent cycle.
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES < 1) ? 0 : GAP_CYCLES - 1);

   state_t             state, state_d;
   logic [CNT_W-1:0]   hold_cnt, gap_cnt;
   logic [NOTE_W-1:0]  note_d, pick_note, grant_note;
   logic [N_SRC-1:0]   grant_d, valid, pick;
   logic               busy_d;
   logic               grant_valid, grant_kill, preempt, note_change, hold_done;

   assign valid = req & en_mask & {note2 != NOTE_REST, note1 != NOTE_REST, note0 != NOTE_REST};
   assign pick  = pick_first(valid);

   always_comb begin
      pick_note = NOTE_REST;
      if (pick[SRC_KEYS])       pick_note = note0;
      else if (pick[SRC_AUTO])  pick_note = note1;
      else if (pick[SRC_LEARN]) pick_note = note2;
   end

   always_comb begin
      grant_note = NOTE_REST;
      if (grant[SRC_KEYS])       grant_note = note0;
      else if (grant[SRC_AUTO])  grant_note = note1;
      else if (grant[SRC_LEARN]) grant_note = note2;
   end

   // grant-1 masks every source with higher priority than the one granted.
   assign grant_valid = |(valid & grant);
   assign grant_kill  = ~|(en_mask & grant);
   assign preempt     = |(valid & (grant - 3'd1));
   assign note_change = grant_valid && (grant_note != note);
   assign hold_done   = ({1'b0, hold_cnt} + 1'b1) >= HOLD_CMP;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         hold_cnt <= '0;
         gap_cnt  <= '0;
         note     <= NOTE_REST;
         grant    <= '0;
         busy     <= 1'b0;
      end else begin
         state <= state_d;
         note  <= note_d;
         grant <= grant_d;
         busy  <= busy_d;
         if (state != ST_PLAY)       hold_cnt <= '0;
         else if (hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
         if (state != ST_GAP)        gap_cnt <= '0;
         else if (gap_cnt < GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE: if (|valid) state_d = ST_PLAY;
         ST_PLAY: if (grant_kill || preempt || note_change || (!grant_valid && hold_done))
                     state_d = ST_GAP;
         ST_GAP:  if (gap_cnt >= GAP_LAST) state_d = (|valid) ? ST_PLAY : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      note_d  = NOTE_REST;
      grant_d = '0;
      busy_d  = (state_d != ST_IDLE);
      if (state_d == ST_PLAY) begin
         if (state == ST_PLAY) begin
            note_d  = note;
            grant_d = grant;
         end else begin
            note_d  = pick_note;
            grant_d = pick;
         end
      end
   end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed and randomized bench for buzzer_arbiter against a cycle-level
// behavioural model of who is sounding and how much silence remains.
module tb_buzzer_arbiter;

   localparam int GAP = 4;
   localparam int HOLD = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] req;
   logic [4:0] note0, note1, note2;
   logic [2:0] en_mask;
   logic [4:0] note;
   logic [2:0] grant;
   logic       busy;

   int total = 0;
   int bad   = 0;

   // model: sounding source (-1 none), its note, cycles sounded, gap cycles left
   int m_src, m_note, m_played, m_gap;

   buzzer_arbiter #(.GAP_CYCLES(GAP), .MIN_HOLD(HOLD)) dut (
      .clk(clk), .rst(rst), .req(req),
      .note0(note0), .note1(note1), .note2(note2),
      .en_mask(en_mask), .note(note), .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_src = -1; m_note = 0; m_played = 0; m_gap = 0;
   endtask

   task automatic model_step();
      int  nts[3];
      bit  v[3];
      int  best;
      bit  leave;
      nts[0] = int'(note0); nts[1] = int'(note1); nts[2] = int'(note2);
      best = -1;
      for (int i = 2; i >= 0; i--) begin
         v[i] = req[i] && en_mask[i] && (nts[i] != 0);
         if (v[i]) best = i;
      end
      if (m_gap > 0) begin
         m_gap--;
         if (m_gap == 0 && best >= 0) begin
            m_src = best; m_note = nts[best]; m_played = 0;
         end
      end else if (m_src >= 0) begin
         m_played++;
         leave = !en_mask[m_src]
              || (best >= 0 && best < m_src)
              || (v[m_src] && nts[m_src] != m_note)
              || (!v[m_src] && m_played >= HOLD);
         if (leave) begin
            m_src = -1;
            m_gap = (GAP < 1) ? 1 : GAP;
         end
      end else if (best >= 0) begin
         m_src = best; m_note = nts[best]; m_played = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [7:0] en, eg, eb;
      en = (m_src >= 0) ? 8'(m_note) : 8'd0;
      eg = (m_src >= 0) ? 8'(1 << m_src) : 8'd0;
      eb = (m_src >= 0 || m_gap > 0) ? 8'd1 : 8'd0;
      chk({tag, "_note"},  {3'b0, note},  en);
      chk({tag, "_grant"}, {5'b0, grant}, eg);
      chk({tag, "_busy"},  {7'b0, busy},  eb);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (!rst) model_step();
      #1;
      check_model(tag);
   endtask

   task automatic ticks(input string tag, input int n);
      for (int k = 0; k < n; k++) tick(tag);
   endtask

   initial begin
      logic [4:0] pool [4];
      pool[0] = 5'd0; pool[1] = 5'd3; pool[2] = 5'd7; pool[3] = 5'd12;

      rst = 1'b1; req = '0; note0 = '0; note1 = '0; note2 = '0; en_mask = 3'b111;
      model_reset();
      #3;
      check_model("reset");
      tick("reset_held");
      rst = 1'b0;
      tick("idle");

      // idle to play
      req = 3'b010; note1 = 5'd8;
      tick("idle2play");
      chk("idle2play_lit_note", {3'b0, note}, 8'd8);
      chk("idle2play_lit_grant", {5'b0, grant}, 8'd2);
      ticks("play1", 2);

      // preemption by keys
      req = 3'b011; note0 = 5'd12;
      for (int k = 0; k < 4; k++) begin
         tick("preempt_gap");
         chk("preempt_gap_lit", {3'b0, note}, 8'd0);
      end
      tick("preempt_play");
      chk("preempt_lit_note", {3'b0, note}, 8'd12);
      chk("preempt_lit_grant", {5'b0, grant}, 8'd1);
      req = 3'b000;
      ticks("drain1", 16);

      // minimum hold on learn prompt
      req = 3'b100; note2 = 5'd5;
      ticks("hold_start", 2);
      req = 3'b000;
      for (int k = 0; k < 6; k++) begin
         tick("hold_wait");
         chk("hold_lit_note", {3'b0, note}, 8'd5);
      end
      ticks("hold_gap", 4);
      tick("hold_idle");
      chk("hold_lit_idle_busy", {7'b0, busy}, 8'd0);

      // note change on auto player
      req = 3'b010; note1 = 5'd10;
      ticks("chg_a", 3);
      note1 = 5'd9;
      ticks("chg_gap", 4);
      tick("chg_new");
      chk("chg_lit_note", {3'b0, note}, 8'd9);

      // mask kill, then reset mid-GAP
      en_mask = 3'b101;
      tick("mask_kill");
      chk("mask_lit_busy", {7'b0, busy}, 8'd1);
      chk("mask_lit_grant", {5'b0, grant}, 8'd0);
      #2 rst = 1'b1;
      #1 model_reset();
      check_model("rst_gap");
      tick("rst_gap_held");
      rst = 1'b0;
      en_mask = 3'b111;
      tick("rst_gap_restart");
      chk("restart_lit_note", {3'b0, note}, 8'd9);

      // reset mid-PLAY
      ticks("play2", 3);
      #2 rst = 1'b1;
      #1 model_reset();
      check_model("rst_play");
      chk("rst_play_lit_note", {3'b0, note}, 8'd0);
      tick("rst_play_held");
      rst = 1'b0;
      tick("rst_play_restart");

      // randomized traffic with sticky inputs
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 4))
               0: req     = 3'($urandom_range(0, 7));
               1: en_mask = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
               2: note0   = pool[$urandom_range(0, 3)];
               3: note1   = pool[$urandom_range(0, 3)];
               default: note2 = pool[$urandom_range(0, 3)];
            endcase
         end
         tick("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
